limb_add_seq: RTL and testbench
===============================

Name: limb_add_seq

Overview:
Multi-precision add/subtract sequencer. It consumes operands as a stream of 64-bit limbs, least significant limb first, and drives one adder64 instance per beat. The carry is chained between beats through a register, and the block emits one registered sum limb per accepted beat. It sits directly upstream of adder64, feeding it operands and carry-in, and turns the combinational adder into a streaming N×64-bit datapath.

Parameters:
MAX_LIMBS, 4, maximum limbs per message (256-bit operands by default); must be ≥2.
IDX_W, $clog2(MAX_LIMBS), width of the limb index.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input limb valid
in_ready  out  1  block can accept a limb
in_a  in  64  operand A limb
in_b  in  64  operand B limb
in_first  in  1  first (least significant) limb of a message
in_last  in  1  last (most significant) limb of a message
in_sub  in  1  mode for the message (1 = A−B), sampled only on the first beat
out_valid  out  1  result limb valid
out_ready  in  1  downstream accepts the result
out_sum  out  64  result limb
out_first  out  1  copy of the first flag for this beat
out_last  out  1  copy of the last flag for this beat
out_idx  out  IDX_W  limb index within the message
out_carry  out  1  carry-out of the message; valid when out_last=1, otherwise 0
out_ovf  out  1  signed overflow of the message; valid when out_last=1, otherwise 0
out_err  out  1  protocol/length error flagged on this beat

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, all other out_* =0, carry_q=0, sub_q=0, idx_q=0, state=IDLE. in_ready=1 out of reset.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
  - Result appears the cycle after acceptance (latency 1). Full throughput with out_ready held high.
  - Output is held stable while out_valid && !out_ready; no beat is accepted in that state.
  - in_ready must not depend on in_valid.
- Datapath per accepted beat:
  - sub_eff = in_first ? in_sub : sub_q.
  - bop = sub_eff ? ~in_b : in_b.
  - cin = first_eff ? sub_eff : carry_q.
  - adder64 inputs are in_a, bop, cin. Its sum is registered to out_sum and its cout to carry_q.
  - For subtract, out_carry=1 means no borrow.
  - Signed overflow on the last beat: out_ovf = cout ^ (in_a[63] ^ bop[63] ^ sum[63]).
- State machine (IDLE / BUSY):
  - IDLE, first=1: start a message; idx=0; latch sub_q. Go to BUSY, or stay in IDLE if last=1 (single-limb message).
  - IDLE, first=0: treat the beat as first_eff with add mode (sub_eff=0, cin=0), set out_err=1, then follow the same transitions.
  - BUSY, first=0: idx increments, carry chains. last=1 returns to IDLE.
  - BUSY, first=1: the previous message is abandoned and a new one starts on this beat. out_err=1 on this beat. Carry and mode are reinitialised.
- Length limit:
  - A beat accepted at idx = MAX_LIMBS−1 without last forces the next beats' out_err=1 until last.
  - idx saturates at MAX_LIMBS−1; it does not wrap.
  - The sum is still computed and emitted.
- Flag gating: out_carry and out_ovf are forced to 0 when out_last=0.
- Reset mid-message: everything returns to reset values immediately. Any pending output beat is dropped, and the next message must start with first.
- Simultaneous output drain and input accept in the same cycle: the new result replaces the old one, with no bubble.

Decomposition:
- Package limb_add_pkg:
  - LIMB_W=64 constant.
  - State enum typedef {IDLE, BUSY}.
  - Packed struct res_t {sum, first, last, idx, carry, ovf, err} for the output register.
- Sub-module: one instance of the existing adder64, with cin driven by the sequencer and cout captured into carry_q. Its group p_g/g_g outputs are left unconnected.
- All control logic stays in limb_add_seq.

Test Plan:
1. 128-bit add, 2 beats: limb0 A=FFFF_FFFF_FFFF_FFFF, B=1, first → sum 0, idx 0. limb1 A=0, B=0, last → sum 1, idx 1, out_carry 0, out_ovf 0.
2. Single-beat subtract, sub=1, A=5, B=7 → sum FFFF_FFFF_FFFF_FFFE, out_carry 0 (borrow), out_ovf 0. Repeat with A=7, B=5 → sum 2, out_carry 1.
3. Signed overflow, single beat, add: A=7FFF_FFFF_FFFF_FFFF, B=1 → sum 8000_0000_0000_0000, out_ovf 1, out_carry 0.
4. Backpressure: stream 4 limbs back-to-back and drop out_ready for 3 cycles after the 2nd result → in_ready=0 for those cycles, out_sum/out_idx stable. All 4 results arrive in order with correct carry chaining. With out_ready high, throughput is 1 beat/cycle.
5. Protocol errors:
   - Beat without first in IDLE → out_err=1, add with cin=0.
   - first mid-message → out_err=1 and carry restarts.
   - 5 limbs with MAX_LIMBS=4 → out_err=1 on the 5th beat, idx stays 3.
6. Reset mid-message: assert rst_n=0 asynchronously between limb1 and limb2 of a 4-limb message → out_valid drops immediately. A fresh 1-limb add, A=2, B=3 → sum 5, idx 0, out_err 0.

Source files
------------

// File: rtl/limb_add_pkg.sv
// Shared types for the multi-precision limb add/subtract sequencer.
package limb_add_pkg;

    localparam int LIMB_W        = 64;
    // Default message length; the output record's index field is sized from it.
    localparam int DEF_MAX_LIMBS = 4;
    localparam int RES_IDX_W     = $clog2(DEF_MAX_LIMBS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [LIMB_W-1:0]    sum;
        logic                 first;
        logic                 last;
        logic [RES_IDX_W-1:0] idx;
        logic                 carry;
        logic                 ovf;
        logic                 err;
    } res_t;

endpackage

// File: rtl/limb_add_seq_if.sv
// Limb stream in, result limb stream out, valid/ready on both sides.
interface limb_add_seq_if #(
    parameter int IDX_W = 2
);
    import limb_add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] in_a;
    logic [LIMB_W-1:0] in_b;
    logic              in_first;
    logic              in_last;
    logic              in_sub;

    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] out_sum;
    logic              out_first;
    logic              out_last;
    logic [IDX_W-1:0]  out_idx;
    logic              out_carry;
    logic              out_ovf;
    logic              out_err;

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_first, out_last, out_idx,
               out_carry, out_ovf, out_err
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_first, out_last, out_idx,
               out_carry, out_ovf, out_err
    );

endinterface

// File: rtl/adder64.sv
// 64-bit combinational adder with carry-in/out and group propagate/generate.
module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        p_g,
    output logic        g_g
);

    logic [64:0] full;
    logic [64:0] no_cin;

    assign full   = {1'b0, a} + {1'b0, b} + {64'b0, cin};
    assign no_cin = {1'b0, a} + {1'b0, b};

    assign sum  = full[63:0];
    assign cout = full[64];
    assign p_g  = &(a ^ b);
    assign g_g  = no_cin[64];

endmodule

// File: rtl/limb_add_seq.sv
// Streaming N x 64-bit add/subtract: one limb per beat, LS limb first,
// carry chained through a register, one registered result limb per beat.
module limb_add_seq
    import limb_add_pkg::*;
#(
    parameter int MAX_LIMBS = DEF_MAX_LIMBS,
    parameter int IDX_W     = $clog2(MAX_LIMBS)
) (
    input  logic           clk,
    input  logic           rst_n,
    limb_add_seq_if.slave  bus
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MAX_LIMBS - 1);

    state_t            state_q;
    logic              carry_q;
    logic              sub_q;
    logic              len_q;
    logic [IDX_W-1:0]  idx_q;
    logic              out_valid_q;
    res_t              res_q;

    logic              in_ready;
    logic              accept;
    logic              first_eff;
    logic              sub_eff;
    logic [LIMB_W-1:0] bop;
    logic              cin;
    logic [LIMB_W-1:0] sum;
    logic              cout;
    logic [IDX_W-1:0]  idx_n;
    logic              err_n;
    logic              ovf_raw;
    res_t              res_n;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // A beat arriving in IDLE always opens a message, even without first;
    // it then runs in add mode because no mode was ever sampled for it.
    always_comb begin
        first_eff = bus.in_first || (state_q == IDLE);
        sub_eff   = bus.in_first ? bus.in_sub : ((state_q == IDLE) ? 1'b0 : sub_q);
        bop       = sub_eff ? ~bus.in_b : bus.in_b;
        cin       = first_eff ? sub_eff : carry_q;
    end

    adder64 u_adder (
        .a    (bus.in_a),
        .b    (bop),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .p_g  (),
        .g_g  ()
    );

    // Next index, error flag and result record for the beat on the inputs.
    always_comb begin
        if (first_eff)
            idx_n = '0;
        else if (idx_q == IDX_TOP)
            idx_n = idx_q;
        else
            idx_n = idx_q + IDX_W'(1);

        err_n = ((state_q == IDLE) && !bus.in_first)
              || ((state_q == BUSY) && bus.in_first)
              || (!first_eff && len_q);

        ovf_raw = cout ^ (bus.in_a[LIMB_W-1] ^ bop[LIMB_W-1] ^ sum[LIMB_W-1]);

        res_n       = '0;
        res_n.sum   = sum;
        res_n.first = bus.in_first;
        res_n.last  = bus.in_last;
        res_n.idx   = RES_IDX_W'(idx_n);
        res_n.carry = bus.in_last && cout;
        res_n.ovf   = bus.in_last && ovf_raw;
        res_n.err   = err_n;
    end

    // Sequencer FSM, carry/mode/index state and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            len_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (in_ready)
                out_valid_q <= accept;
            if (accept) begin
                state_q <= bus.in_last ? IDLE : BUSY;
                sub_q   <= sub_eff;
                carry_q <= cout;
                idx_q   <= idx_n;
                // Once the top index is passed without last, every further
                // beat of this message is over length until last arrives.
                len_q   <= !bus.in_last && (idx_n == IDX_TOP);
                res_q   <= res_n;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = res_q.sum;
    assign bus.out_first = res_q.first;
    assign bus.out_last  = res_q.last;
    assign bus.out_idx   = IDX_W'(res_q.idx);
    assign bus.out_carry = res_q.carry;
    assign bus.out_ovf   = res_q.ovf;
    assign bus.out_err   = res_q.err;

endmodule

// File: tb/tb_limb_add_seq.sv
// Directed bench for limb_add_seq with hand-computed expected results.
module tb_limb_add_seq;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    limb_add_seq_if #(.IDX_W(2)) bus ();

    limb_add_seq #(.MAX_LIMBS(4), .IDX_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic f, input logic l, input logic s);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_sub   = s;
    endtask

    // One beat with out_ready high; outputs are sampled 1 ns after the edge.
    task automatic beat(input logic [63:0] a, input logic [63:0] b,
                        input logic f, input logic l, input logic s);
        drive(a, b, f, l, s);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] sum, input logic [1:0] idx,
                           input logic carry, input logic ovf, input logic err);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".sum"},   bus.out_sum, sum);
        chk({tag, ".idx"},   64'(bus.out_idx), 64'(idx));
        chk({tag, ".carry"}, 64'(bus.out_carry), 64'(carry));
        chk({tag, ".ovf"},   64'(bus.out_ovf), 64'(ovf));
        chk({tag, ".err"},   64'(bus.out_err), 64'(err));
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst.valid", 64'(bus.out_valid), 64'd0);
        chk("rst.ready", 64'(bus.in_ready), 64'd1);
        chk("rst.sum",   bus.out_sum, 64'd0);
        chk("rst.last",  64'(bus.out_last), 64'd0);

        // 128-bit add across two limbs
        beat(ONES, 64'd1, 1'b1, 1'b0, 1'b0);
        chk_out("add128.l0", 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("add128.l0.first", 64'(bus.out_first), 64'd1);
        beat(64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk_out("add128.l1", 64'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("add128.l1.last", 64'(bus.out_last), 64'd1);

        // Single-beat subtracts
        beat(64'd5, 64'd7, 1'b1, 1'b1, 1'b1);
        chk_out("sub5m7", 64'hFFFF_FFFF_FFFF_FFFE, 2'd0, 1'b0, 1'b0, 1'b0);
        beat(64'd7, 64'd5, 1'b1, 1'b1, 1'b1);
        chk_out("sub7m5", 64'd2, 2'd0, 1'b1, 1'b0, 1'b0);

        // Signed overflow
        beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 1'b0);
        chk_out("ovf", 64'h8000_0000_0000_0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream with a 3-cycle stall after the 2nd result
        drive(ONES, 64'd2, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("bp.l0", 64'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("bp.l1", 64'd31, 2'd1, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        drive(ONES, ONES, 1'b0, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp.stall.ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("bp.stall.valid", 64'(bus.out_valid), 64'd1);
            chk("bp.stall.sum", bus.out_sum, 64'd31);
            chk("bp.stall.idx", 64'(bus.out_idx), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.resume.ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk_out("bp.l2", 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b0, 1'b0, 1'b0);
        drive(64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_out("bp.l3", 64'd3, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("bp.l3.last", 64'(bus.out_last), 64'd1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp.drain.valid", 64'(bus.out_valid), 64'd0);

        // Beat without first while idle: add mode, cin=0, flagged
        beat(ONES, 64'd1, 1'b0, 1'b1, 1'b1);
        chk_out("nofirst", 64'd0, 2'd0, 1'b1, 1'b0, 1'b1);

        // first mid-message restarts the carry
        beat(ONES, 64'd1, 1'b1, 1'b0, 1'b0);
        chk_out("restart.l0", 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        beat(64'd5, 64'd6, 1'b1, 1'b1, 1'b0);
        chk_out("restart.l1", 64'd11, 2'd0, 1'b0, 1'b0, 1'b1);

        // Over-length message: 5 limbs with MAX_LIMBS=4
        beat(64'd1, 64'd1, 1'b1, 1'b0, 1'b0);
        chk_out("len.l0", 64'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        beat(64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
        chk_out("len.l1", 64'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        beat(64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
        chk_out("len.l2", 64'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        beat(64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
        chk_out("len.l3", 64'd2, 2'd3, 1'b0, 1'b0, 1'b0);
        beat(64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
        chk_out("len.l4", 64'd2, 2'd3, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-message
        beat(64'd1, 64'd1, 1'b1, 1'b0, 1'b0);
        beat(64'd2, 64'd2, 1'b0, 1'b0, 1'b0);
        chk("rstmid.pre.valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid.sum", bus.out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(64'd2, 64'd3, 1'b1, 1'b1, 1'b0);
        chk_out("rstmid.fresh", 64'd5, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
